addr_decoder_ws: RTL and testbench
==================================

# addr_decoder_ws

Parametrised, registered address decoder for the MIPS system bus. It generalises the fixed four-region chip-select decoder to N regions, each with a programmable base, mask and wait-state count. It adds a request/ready handshake, a bus-error response for unmapped addresses, and a sticky error-address capture register. It sits between the CPU bus interface and the memory/TC/UART/GPIO peripherals and gives each slave an active-low chip select that is held for the whole access.

## Interface
- `N_REG`, default 4: number of decoded regions (1..16).
- `ADDR_W`, default 32: address width.
- `BASE`, default {FFFF_2000, FFFF_1000, FFFF_0000, 0000_0000}: packed N_REG×ADDR_W region bases; region i occupies slice i.
- `MASK`, default {FFFF_F000, FFFF_F000, FFFF_F000, FFFF_E000}: packed N_REG×ADDR_W match masks.
- `WS`, default {2, 3, 1, 0}: packed N_REG×4 wait states per region.
- `clk` in 1: system clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `req` in 1: access request; master holds it high until `ready` or `bus_err` is seen.
- `addr` in ADDR_W: access address; sampled only when a request is accepted.
- `err_clr` in 1: clears `err_flag` and `err_addr`.
- `cs_n` out N_REG: registered active-low chip selects, at most one low at a time.
- `sel_idx` out $clog2(N_REG) (minimum 1): index of the active region; 0 when idle.
- `ready` out 1: one-cycle completion pulse.
- `bus_err` out 1: one-cycle pulse for an unmapped access.
- `err_flag` out 1: sticky error indicator.
- `err_addr` out ADDR_W: address of the first unmapped access since the last clear.

## Operation
- Region i matches when `(addr & MASK[i]) == BASE[i]`. If regions overlap, the lowest index wins.
- FSM states: IDLE, ACCESS, ERR.
- **IDLE**, `req`=1, match found:
  - latch idx and the address;
  - load `cnt` = WS[idx];
  - drive `cs_n[idx]` low;
  - go to ACCESS.
- **IDLE**, `req`=1, no match: go to ERR. No chip select asserts.
- **ACCESS**:
  - `ready` = (`cnt` == 0), decoded combinationally from the state registers;
  - while `cnt` != 0, decrement `cnt` each cycle;
  - when `cnt` == 0, deassert all `cs_n` and return to IDLE.
- **ERR**: `bus_err` = 1 for exactly one cycle, then return to IDLE.
  - If `err_flag` is 0: set it and capture the address into `err_addr`.
  - If `err_flag` is already 1: `err_addr` keeps the first error address.
- `req` is ignored outside IDLE; `addr` changes during an access have no effect.
- Back-to-back accesses: if `req` is still high in the cycle after `ready`/`bus_err`, a new access is accepted in that cycle.
- `err_clr` and a new error in the same cycle: the set wins, and `err_addr` captures the new address.
- Reset, asynchronous at any point including mid-access:
  - state = IDLE, `cnt` = 0;
  - `cs_n` = all 1s, `sel_idx` = 0;
  - `ready` = 0, `bus_err` = 0, `err_flag` = 0, `err_addr` = 0.
- A cancelled access produces no `ready`.

## Timing
- `req` is sampled at rising edge E0. `cs_n` falls after E0.
- `ready` is high during cycle E0+WS … E0+WS+1, i.e. WS+1 cycles after the request cycle.
- `cs_n` rises after edge E0+WS+1. Chip-select width = WS+1 cycles.
- Unmapped access: `bus_err` is high in the cycle after E0. `err_flag` is visible one cycle later.
- Throughput with `req` held high continuously: one access per WS+1 cycles. There are no idle bubbles, but `cs_n` for consecutive accesses to the same region stays low only if the FSM re-enters ACCESS directly; otherwise it goes high for ≥1 cycle between accesses.
- WS width is 4 bits, so the maximum is 15 wait states and `cnt` never wraps.

## Structure
- Package `addr_dec_pkg`:
  - state enum {IDLE, ACCESS, ERR};
  - `WS_W` = 4;
  - default BASE/MASK/WS constants for the four-slave system map.
- Sub-module `region_match`: purely combinational array of N_REG mask comparators plus a lowest-index priority encoder. Outputs `hit` and `idx`.
- The top level holds the FSM, wait counter, chip-select register and error capture.

## Test plan
- Default map, `req` with `addr`=0000_1FFC: `cs_n`=1110 for 1 cycle, `ready` in the same cycle, `sel_idx`=0.
- `addr`=FFFF_1008 (WS=3): `cs_n`=1011 for 4 cycles, `ready` in the 4th cycle only, then `cs_n`=1111.
- `addr`=8000_0000:
  - `bus_err` pulses once, `cs_n` stays 1111;
  - `err_flag`=1, `err_addr`=8000_0000;
  - a second bad address, 0000_4000, leaves `err_addr` unchanged;
  - `err_clr` zeroes both.
- `req` held high alternating FFFF_0000 / FFFF_2000: `ready` pulses at cycles 2 and 5 (WS 1 then 2); `addr` toggled mid-access is ignored.
- `rst_n` asserted low during cycle 2 of a WS=3 access: `cs_n`=1111 and `ready`=0 immediately. After release with `req`=0, the block stays in IDLE.
- Overlap: N_REG=2, BASE={0000_0000, 0000_0000}, MASK={FFFF_0000, FFFF_F000}, `addr`=0000_0010: region 0 is selected.

Source files
------------

// File: rtl/addr_dec_pkg.sv
// Shared definitions for the MIPS system-bus address decoder.
//   state_e            : decoder FSM states
//   WS_W               : width of one wait-state field
//   DEF_BASE/MASK/WS   : default four-slave system map
//                        (region 0 = memory, 1 = TC, 2 = UART, 3 = GPIO)
package addr_dec_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        ERR    = 2'd2
    } state_e;

    localparam int WS_W = 4;

    // Region i occupies slice i of each packed vector.
    localparam logic [4*32-1:0] DEF_BASE = {32'hFFFF_2000, 32'hFFFF_1000,
                                            32'hFFFF_0000, 32'h0000_0000};
    localparam logic [4*32-1:0] DEF_MASK = {32'hFFFF_F000, 32'hFFFF_F000,
                                            32'hFFFF_F000, 32'hFFFF_E000};
    localparam logic [4*WS_W-1:0] DEF_WS = {4'd2, 4'd3, 4'd1, 4'd0};

endpackage

// File: rtl/region_match.sv
// Combinational region matcher: N_REG mask comparators followed by a
// lowest-index priority encoder, so overlapping regions resolve to the
// lowest index.
//   addr : address under test
//   hit  : at least one region matches
//   idx  : index of the lowest matching region (0 when no hit)
module region_match #(
    parameter int                        N_REG  = 4,
    parameter int                        ADDR_W = 32,
    parameter int                        SEL_W  = 2,
    parameter logic [N_REG*ADDR_W-1:0]   BASE   = '0,
    parameter logic [N_REG*ADDR_W-1:0]   MASK   = '0
) (
    input  logic [ADDR_W-1:0] addr,
    output logic              hit,
    output logic [SEL_W-1:0]  idx
);

    always_comb begin
        // NOTE: every output gets a default before the loop so no path leaves it unassigned (no latch).
        hit = 1'b0;
        idx = '0;
        // Scan from the top down; the last match written is the lowest index.
        for (int i = N_REG - 1; i >= 0; i--) begin
            if ((addr & MASK[i*ADDR_W +: ADDR_W]) == BASE[i*ADDR_W +: ADDR_W]) begin
                hit = 1'b1;
                idx = SEL_W'(i);
            end
        end
    end

endmodule

// File: rtl/addr_decoder_ws.sv
// Registered N-region address decoder with per-region wait states.
//   clk, rst_n : system clock (rising edge), asynchronous active-low reset
//   req        : access request, only acted on when the decoder is free
//   addr       : access address, sampled when a request is accepted
//   err_clr    : clears err_flag / err_addr (a same-cycle new error wins)
//   cs_n       : registered active-low chip selects, at most one low
//   sel_idx    : index of the active region, 0 when idle
//   ready      : one-cycle completion pulse for a mapped access
//   bus_err    : one-cycle pulse for an unmapped access
//   err_flag   : sticky error indicator
//   err_addr   : first unmapped address since the last clear
module addr_decoder_ws
    import addr_dec_pkg::*;
#(
    parameter int                        N_REG  = 4,
    parameter int                        ADDR_W = 32,
    parameter logic [N_REG*ADDR_W-1:0]   BASE   = DEF_BASE,
    parameter logic [N_REG*ADDR_W-1:0]   MASK   = DEF_MASK,
    parameter logic [N_REG*WS_W-1:0]     WS     = DEF_WS,
    localparam int                       SEL_W  = (N_REG > 1) ? $clog2(N_REG) : 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req,
    input  logic [ADDR_W-1:0] addr,
    input  logic              err_clr,
    output logic [N_REG-1:0]  cs_n,
    output logic [SEL_W-1:0]  sel_idx,
    output logic              ready,
    output logic              bus_err,
    output logic              err_flag,
    output logic [ADDR_W-1:0] err_addr
);

    state_e              state_q, state_d;
    logic [WS_W-1:0]     cnt_q, cnt_d;
    logic [N_REG-1:0]    cs_n_q, cs_n_d;
    logic [SEL_W-1:0]    sel_q, sel_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic                err_flag_q;
    logic [ADDR_W-1:0]   err_addr_q;

    logic                hit;
    logic [SEL_W-1:0]    idx;
    logic                done;
    logic                accept;

    region_match #(
        .N_REG  (N_REG),
        .ADDR_W (ADDR_W),
        .SEL_W  (SEL_W),
        .BASE   (BASE),
        .MASK   (MASK)
    ) u_match (
        .addr (addr),
        .hit  (hit),
        .idx  (idx)
    );

    // The final cycle of an access (ready) or of an error (bus_err) frees
    // the decoder, so a request held high is accepted right there and
    // back-to-back accesses run without idle bubbles.
    assign done   = ((state_q == ACCESS) && (cnt_q == '0)) || (state_q == ERR);
    assign accept = req && ((state_q == IDLE) || done);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        cs_n_d  = cs_n_q;
        sel_d   = sel_q;
        addr_d  = addr_q;

        unique case (state_q)
            IDLE: ;
            ACCESS: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - WS_W'(1);
                end else begin
                    state_d = IDLE;
                    cs_n_d  = '1;
                    sel_d   = '0;
                end
            end
            ERR: state_d = IDLE;
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
                cs_n_d  = '1;
                sel_d   = '0;
            end
        endcase

        // A newly accepted request overrides the completion defaults above;
        // re-selecting the same region keeps its chip select low throughout.
        if (accept) begin
            addr_d = addr;
            if (hit) begin
                state_d = ACCESS;
                cnt_d   = WS[int'(idx)*WS_W +: WS_W];
                cs_n_d  = ~(N_REG'(1) << idx);
                sel_d   = idx;
            end else begin
                state_d = ERR;
                cnt_d   = '0;
                cs_n_d  = '1;
                sel_d   = '0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            cs_n_q     <= '1;
            sel_q      <= '0;
            addr_q     <= '0;
            err_flag_q <= 1'b0;
            err_addr_q <= '0;
        end else begin
            // NOTE: non-blocking assignments so every register updates from pre-edge values.
            state_q <= state_d;
            cnt_q   <= cnt_d;
            cs_n_q  <= cs_n_d;
            sel_q   <= sel_d;
            addr_q  <= addr_d;

            // Only the first error since a clear is captured; a clear in the
            // same cycle as a new error lets the new error through.
            if ((state_q == ERR) && (err_clr || !err_flag_q)) begin
                err_flag_q <= 1'b1;
                err_addr_q <= addr_q;
            end else if (err_clr) begin
                err_flag_q <= 1'b0;
                err_addr_q <= '0;
            end
        end
    end

    assign cs_n     = cs_n_q;
    assign sel_idx  = sel_q;
    assign ready    = (state_q == ACCESS) && (cnt_q == '0);
    assign bus_err  = (state_q == ERR);
    assign err_flag = err_flag_q;
    assign err_addr = err_addr_q;

endmodule

// File: tb/tb_addr_decoder_ws.sv
// Self-checking bench for addr_decoder_ws. Expected behaviour comes from a
// region table and a simple per-access timing model kept in the bench.
module tb_addr_decoder_ws;

    localparam logic [31:0] M_BASE [4] = '{32'h0000_0000, 32'hFFFF_0000, 32'hFFFF_1000, 32'hFFFF_2000};
    localparam logic [31:0] M_MASK [4] = '{32'hFFFF_E000, 32'hFFFF_F000, 32'hFFFF_F000, 32'hFFFF_F000};
    localparam int          M_WS   [4] = '{0, 1, 3, 2};

    localparam logic [31:0] OV_BASE [2] = '{32'h0000_0000, 32'h0000_0000};
    localparam logic [31:0] OV_MASK [2] = '{32'hFFFF_F000, 32'hFFFF_0000};

    logic        clk;
    logic        rst_n;
    logic        req;
    logic [31:0] addr;
    logic        err_clr;
    logic [3:0]  cs_n;
    logic [1:0]  sel_idx;
    logic        ready;
    logic        bus_err;
    logic        err_flag;
    logic [31:0] err_addr;

    logic        req2;
    logic [31:0] addr2;
    logic [1:0]  cs2_n;
    logic [0:0]  sel2;
    logic        ready2;
    logic        bus_err2;
    logic        err_flag2;
    logic [31:0] err_addr2;

    int checks = 0;
    int errors = 0;

    // Error-capture model
    logic        m_flag  = 1'b0;
    logic [31:0] m_eaddr = '0;

    addr_decoder_ws dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .req      (req),
        .addr     (addr),
        .err_clr  (err_clr),
        .cs_n     (cs_n),
        .sel_idx  (sel_idx),
        .ready    (ready),
        .bus_err  (bus_err),
        .err_flag (err_flag),
        .err_addr (err_addr)
    );

    addr_decoder_ws #(
        .N_REG (2),
        .BASE  ({32'h0000_0000, 32'h0000_0000}),
        .MASK  ({32'hFFFF_0000, 32'hFFFF_F000}),
        .WS    (8'h00)
    ) dut_ov (
        .clk      (clk),
        .rst_n    (rst_n),
        .req      (req2),
        .addr     (addr2),
        .err_clr  (err_clr),
        .cs_n     (cs2_n),
        .sel_idx  (sel2),
        .ready    (ready2),
        .bus_err  (bus_err2),
        .err_flag (err_flag2),
        .err_addr (err_addr2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic int model_match(logic [31:0] a);
        for (int i = 0; i < 4; i++)
            if ((a & M_MASK[i]) == M_BASE[i]) return i;
        return -1;
    endfunction

    // One isolated access: req high for the accepting edge only, then the
    // address bus is scrambled to show it is not re-sampled.
    task automatic do_access(input logic [31:0] a, input string tag);
        int          idx;
        int          ws;
        logic [3:0]  exp_cs;
        idx  = model_match(a);
        req  = 1'b1;
        addr = a;
        step();
        req  = 1'b0;
        addr = $urandom;
        if (idx >= 0) begin
            ws     = M_WS[idx];
            exp_cs = ~(4'b0001 << idx);
            for (int k = 0; k <= ws; k++) begin
                checks++;
                if (cs_n !== exp_cs || sel_idx !== 2'(idx) || ready !== (k == ws) || bus_err !== 1'b0) begin
                    errors++;
                    $display("FAIL %s access cyc%0d addr=%h: cs_n=%b sel=%0d ready=%b bus_err=%b, exp cs_n=%b sel=%0d ready=%b bus_err=0",
                             tag, k, a, cs_n, sel_idx, ready, bus_err, exp_cs, idx, (k == ws));
                end
                step();
            end
            checks++;
            if (cs_n !== 4'hF || ready !== 1'b0 || sel_idx !== 2'd0) begin
                errors++;
                $display("FAIL %s release addr=%h: cs_n=%b ready=%b sel=%0d, exp 1111/0/0", tag, a, cs_n, ready, sel_idx);
            end
        end else begin
            checks++;
            if (bus_err !== 1'b1 || cs_n !== 4'hF || ready !== 1'b0) begin
                errors++;
                $display("FAIL %s buserr addr=%h: bus_err=%b cs_n=%b ready=%b, exp 1/1111/0", tag, a, bus_err, cs_n, ready);
            end
            if (!m_flag) begin
                m_flag  = 1'b1;
                m_eaddr = a;
            end
            step();
            checks++;
            if (bus_err !== 1'b0 || err_flag !== m_flag || err_addr !== m_eaddr) begin
                errors++;
                $display("FAIL %s errcap addr=%h: bus_err=%b flag=%b eaddr=%h, exp 0/%b/%h",
                         tag, a, bus_err, err_flag, err_addr, m_flag, m_eaddr);
            end
        end
    endtask

    task automatic test_reset();
        checks++;
        if (cs_n !== 4'hF || sel_idx !== 2'd0 || ready !== 1'b0 || bus_err !== 1'b0 ||
            err_flag !== 1'b0 || err_addr !== 32'h0) begin
            errors++;
            $display("FAIL reset: cs_n=%b sel=%0d ready=%b bus_err=%b flag=%b eaddr=%h, exp 1111/0/0/0/0/0",
                     cs_n, sel_idx, ready, bus_err, err_flag, err_addr);
        end
        @(negedge clk);
        rst_n = 1'b1;
        step();
        checks++;
        if (cs_n !== 4'hF || ready !== 1'b0) begin
            errors++;
            $display("FAIL reset_idle: cs_n=%b ready=%b, exp 1111/0", cs_n, ready);
        end
    endtask

    task automatic test_single();
        do_access(32'h0000_1FFC, "mem_ws0");
        do_access(32'hFFFF_1008, "uart_ws3");
        do_access(32'hFFFF_0FFF, "tc_ws1");
        do_access(32'hFFFF_2ABC, "gpio_ws2");
    endtask

    task automatic test_errors();
        do_access(32'h8000_0000, "err_first");
        do_access(32'h0000_4000, "err_second");
        err_clr = 1'b1;
        step();
        err_clr = 1'b0;
        m_flag  = 1'b0;
        m_eaddr = '0;
        checks++;
        if (err_flag !== 1'b0 || err_addr !== 32'h0) begin
            errors++;
            $display("FAIL err_clr: flag=%b eaddr=%h, exp 0/00000000", err_flag, err_addr);
        end
        do_access(32'h1234_5678, "err_after_clr");
        // New error while clearing: the new address must be captured.
        req  = 1'b1;
        addr = 32'hDEAD_0000;
        step();
        req     = 1'b0;
        err_clr = 1'b1;
        checks++;
        if (bus_err !== 1'b1) begin
            errors++;
            $display("FAIL err_clr_race buserr: bus_err=%b, exp 1", bus_err);
        end
        step();
        err_clr = 1'b0;
        m_flag  = 1'b1;
        m_eaddr = 32'hDEAD_0000;
        checks++;
        if (err_flag !== 1'b1 || err_addr !== 32'hDEAD_0000) begin
            errors++;
            $display("FAIL err_clr_race: flag=%b eaddr=%h, exp 1/dead0000", err_flag, err_addr);
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] seq [4];
        int          ready_cyc [$];
        int          cyc;
        int          idx;
        int          ws;
        logic [3:0]  exp_cs;
        seq  = '{32'hFFFF_0000, 32'hFFFF_2000, 32'hFFFF_0000, 32'hFFFF_2000};
        req  = 1'b1;
        addr = seq[0];
        step();
        cyc = 1;
        for (int j = 0; j < 4; j++) begin
            idx    = model_match(seq[j]);
            ws     = M_WS[idx];
            exp_cs = ~(4'b0001 << idx);
            for (int k = 0; k <= ws; k++) begin
                checks++;
                if (cs_n !== exp_cs || ready !== (k == ws) || sel_idx !== 2'(idx)) begin
                    errors++;
                    $display("FAIL b2b acc%0d cyc%0d: cs_n=%b ready=%b sel=%0d, exp %b/%b/%0d",
                             j, cyc, cs_n, ready, sel_idx, exp_cs, (k == ws), idx);
                end
                if (ready === 1'b1) ready_cyc.push_back(cyc);
                if (k < ws)      addr = $urandom;
                else if (j < 3)  addr = seq[j+1];
                else             req  = 1'b0;
                step();
                cyc++;
            end
        end
        checks++;
        if (cs_n !== 4'hF || ready !== 1'b0) begin
            errors++;
            $display("FAIL b2b end: cs_n=%b ready=%b, exp 1111/0", cs_n, ready);
        end
        checks++;
        if (ready_cyc.size() < 2 || ready_cyc[0] != 2 || ready_cyc[1] != 5) begin
            errors++;
            $display("FAIL b2b ready_cycles: got %0d pulses first=%0d second=%0d, exp cycles 2 and 5",
                     ready_cyc.size(), (ready_cyc.size() > 0) ? ready_cyc[0] : -1,
                     (ready_cyc.size() > 1) ? ready_cyc[1] : -1);
        end
    endtask

    task automatic test_random();
        int          r;
        logic [31:0] a;
        for (int n = 0; n < 30; n++) begin
            r = $urandom_range(0, 4);
            if (r < 4) a = M_BASE[r] | ($urandom & ~M_MASK[r]);
            else       a = $urandom;
            do_access(a, "random");
        end
    endtask

    task automatic test_overlap();
        int         idx;
        logic [1:0] exp_cs;
        logic [31:0] a;
        a   = 32'h0000_0010;
        idx = -1;
        for (int i = 1; i >= 0; i--)
            if ((a & OV_MASK[i]) == OV_BASE[i]) idx = i;
        exp_cs = ~(2'b01 << idx);
        req2  = 1'b1;
        addr2 = a;
        step();
        req2 = 1'b0;
        checks++;
        if (cs2_n !== exp_cs || sel2 !== 1'(idx) || ready2 !== 1'b1 || bus_err2 !== 1'b0) begin
            errors++;
            $display("FAIL overlap: cs_n=%b sel=%0d ready=%b bus_err=%b, exp %b/%0d/1/0",
                     cs2_n, sel2, ready2, bus_err2, exp_cs, idx);
        end
        step();
        checks++;
        if (cs2_n !== 2'b11 || ready2 !== 1'b0) begin
            errors++;
            $display("FAIL overlap release: cs_n=%b ready=%b, exp 11/0", cs2_n, ready2);
        end
    endtask

    task automatic test_reset_mid();
        req  = 1'b1;
        addr = 32'hFFFF_1008;
        step();
        req = 1'b0;
        checks++;
        if (cs_n !== 4'b1011) begin
            errors++;
            $display("FAIL rst_mid pre: cs_n=%b, exp 1011", cs_n);
        end
        step();
        rst_n = 1'b0;
        #1;
        checks++;
        if (cs_n !== 4'hF || ready !== 1'b0 || sel_idx !== 2'd0 || bus_err !== 1'b0) begin
            errors++;
            $display("FAIL rst_mid async: cs_n=%b ready=%b sel=%0d bus_err=%b, exp 1111/0/0/0",
                     cs_n, ready, sel_idx, bus_err);
        end
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 6; k++) begin
            step();
            checks++;
            if (cs_n !== 4'hF || ready !== 1'b0 || bus_err !== 1'b0 || sel_idx !== 2'd0) begin
                errors++;
                $display("FAIL rst_mid idle cyc%0d: cs_n=%b ready=%b bus_err=%b sel=%0d, exp 1111/0/0/0",
                         k, cs_n, ready, bus_err, sel_idx);
            end
        end
    endtask

    initial begin
        rst_n   = 1'b0;
        req     = 1'b0;
        addr    = '0;
        err_clr = 1'b0;
        req2    = 1'b0;
        addr2   = '0;
        #12;
        test_reset();
        test_single();
        test_errors();
        test_back_to_back();
        test_random();
        test_overlap();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
